// File: rtl/conv3_window_gen.sv
// 3x3 sliding-window generator for the convolution stage.
// Buffers two raster lines and emits one window per interior pixel.
module conv3_window_gen #(
    parameter int IMG_WIDTH  = 8,
    parameter int IMG_HEIGHT = 8,
    parameter int PIX_W      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    input  logic [PIX_W-1:0]              in_pixel,
    output logic                          out_valid,
    output logic [9*PIX_W-1:0]            out_window,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          frame_done
);

    localparam int RW = $clog2(IMG_HEIGHT);
    localparam int CW = $clog2(IMG_WIDTH);

    typedef enum logic {S_FILL, S_RUN} state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [CW-1:0]         r_col;
    logic [RW-1:0]         r_row;
    logic [PIX_W-1:0]      r_line0 [IMG_WIDTH];
    logic [PIX_W-1:0]      r_line1 [IMG_WIDTH];
    logic [8:0][PIX_W-1:0] r_win;
    logic [8:0][PIX_W-1:0] w_win_nxt;
    logic                  w_last_col;
    logic                  w_last_row;
    logic                  w_emit;
    logic                  w_frame_end;

    assign w_last_col = (r_col == CW'(IMG_WIDTH - 1));
    assign w_last_row = (r_row == RW'(IMG_HEIGHT - 1));

    always_comb begin
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_frame_end = 1'b0;
        unique case (r_state)
            S_FILL: begin
                if (in_valid && w_last_col && r_row == RW'(1))
                    w_state_nxt = S_RUN;
            end
            S_RUN: begin
                w_emit      = in_valid && (r_col >= CW'(2));
                w_frame_end = in_valid && w_last_col && w_last_row;
                if (w_frame_end)
                    w_state_nxt = S_FILL;
            end
        endcase
    end

    // Shift left one column; the new right column comes from both lines plus the input.
    always_comb begin
        w_win_nxt = r_win;
        for (int r = 0; r < 3; r++) begin
            w_win_nxt[r*3]   = r_win[r*3+1];
            w_win_nxt[r*3+1] = r_win[r*3+2];
        end
        w_win_nxt[2] = r_line0[r_col];
        w_win_nxt[5] = r_line1[r_col];
        w_win_nxt[8] = in_pixel;
    end

    always_ff @(posedge clk) begin
        if (!rst)
            r_state <= S_FILL;
        else
            r_state <= w_state_nxt;
    end

    // Storage contents need no reset: output is gated until two fresh lines exist.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            r_line0[r_col] <= r_line1[r_col];
            r_line1[r_col] <= in_pixel;
            r_win          <= w_win_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_col      <= '0;
            r_row      <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
            out_row    <= '0;
            out_col    <= '0;
        end else begin
            out_valid  <= w_emit;
            frame_done <= w_frame_end;
            if (w_emit) begin
                out_window <= w_win_nxt;
                out_row    <= r_row;
                out_col    <= r_col;
            end
            if (in_valid) begin
                if (w_last_col) begin
                    r_col <= '0;
                    r_row <= w_last_row ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv3_window_gen.sv
// Directed bench for conv3_window_gen: 4x4 scenarios plus an 8x8 frame
// checked against windows built from the stored image.
module tb_conv3_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    logic        rst4, iv4, ov4, fd4;
    logic [7:0]  px4;
    logic [71:0] ow4;
    logic [1:0]  or4, oc4;

    logic        rst8, iv8, ov8, fd8;
    logic [7:0]  px8;
    logic [71:0] ow8;
    logic [2:0]  or8, oc8;

    conv3_window_gen #(.IMG_WIDTH(4), .IMG_HEIGHT(4), .PIX_W(8)) u4 (
        .clk(clk), .rst(rst4), .in_valid(iv4), .in_pixel(px4),
        .out_valid(ov4), .out_window(ow4), .out_row(or4),
        .out_col(oc4), .frame_done(fd4)
    );

    conv3_window_gen u8 (
        .clk(clk), .rst(rst8), .in_valid(iv8), .in_pixel(px8),
        .out_valid(ov8), .out_window(ow8), .out_row(or8),
        .out_col(oc8), .frame_done(fd8)
    );

    typedef struct {
        logic [71:0] w;
        int          r;
        int          c;
        logic        fd;
        int          cyc;
    } rec_t;

    rec_t q4[$];
    rec_t q8[$];
    logic last_iv4 = 1'b0;
    int   gap_viol = 0;
    int   fd_extra = 0;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        last_iv4 <= iv4;
    end

    // Capture every emitted window; outputs are stable at the falling edge.
    always @(negedge clk) begin
        rec_t t;
        if (ov4) begin
            t = '{ow4, int'(or4), int'(oc4), fd4, cyc};
            q4.push_back(t);
            if (!last_iv4) gap_viol++;
        end else if (fd4) begin
            fd_extra++;
        end
        if (ov8) begin
            t = '{ow8, int'(or8), int'(oc8), fd8, cyc};
            q8.push_back(t);
        end
    end

    logic [71:0] exp4 [4];
    int          er4  [4];
    int          ec4  [4];

    task automatic drive4(input bit gap, input int nfr, output int acc10);
        acc10 = -1;
        for (int f = 0; f < nfr; f++) begin
            for (int i = 0; i < 16; i++) begin
                @(negedge clk);
                iv4 = 1'b1;
                px4 = 8'(f * 64 + i);
                if (f == 0 && i == 10) acc10 = cyc + 1;
                if (gap) begin
                    @(negedge clk);
                    iv4 = 1'b0;
                end
            end
        end
        @(negedge clk);
        iv4 = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        rst4 = 1'b0; rst8 = 1'b0;
        iv4 = 1'b1;  iv8 = 1'b1;
        px4 = 8'h5A; px8 = 8'hA5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++;
            if ({ov4, ow4, or4, oc4, fd4} !== '0) begin
                n_bad++;
                $display("FAIL reset4_%0d: got v=%b w=%h r=%0d c=%0d fd=%b want all 0",
                         i, ov4, ow4, or4, oc4, fd4);
            end
            n_cmp++;
            if ({ov8, ow8, or8, oc8, fd8} !== '0) begin
                n_bad++;
                $display("FAIL reset8_%0d: got v=%b w=%h r=%0d c=%0d fd=%b want all 0",
                         i, ov8, ow8, or8, oc8, fd8);
            end
        end
        iv4 = 1'b0; iv8 = 1'b0;
        rst4 = 1'b1; rst8 = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic;
        int acc;
        q4.delete();
        fd_extra = 0;
        drive4(1'b0, 1, acc);
        n_cmp++;
        if (q4.size() != 4) begin
            n_bad++;
            $display("FAIL basic_count: got %0d want 4", q4.size());
        end
        for (int i = 0; i < q4.size() && i < 4; i++) begin
            n_cmp++;
            if (q4[i].w !== exp4[i] || q4[i].r != er4[i] || q4[i].c != ec4[i]
                || q4[i].fd !== (i == 3)) begin
                n_bad++;
                $display("FAIL basic_win%0d: got %h (%0d,%0d) fd=%b want %h (%0d,%0d) fd=%b",
                         i, q4[i].w, q4[i].r, q4[i].c, q4[i].fd,
                         exp4[i], er4[i], ec4[i], i == 3);
            end
        end
        if (q4.size() > 0) begin
            n_cmp++;
            if (q4[0].cyc != acc) begin
                n_bad++;
                $display("FAIL basic_latency: got cycle %0d want %0d", q4[0].cyc, acc);
            end
        end
        n_cmp++;
        if (fd_extra != 0) begin
            n_bad++;
            $display("FAIL basic_fd_stray: got %0d want 0", fd_extra);
        end
    endtask

    task automatic test_gapped;
        int acc;
        q4.delete();
        gap_viol = 0;
        drive4(1'b1, 1, acc);
        n_cmp++;
        if (q4.size() != 4) begin
            n_bad++;
            $display("FAIL gap_count: got %0d want 4", q4.size());
        end
        for (int i = 0; i < q4.size() && i < 4; i++) begin
            n_cmp++;
            if (q4[i].w !== exp4[i] || q4[i].r != er4[i] || q4[i].c != ec4[i]) begin
                n_bad++;
                $display("FAIL gap_win%0d: got %h (%0d,%0d) want %h (%0d,%0d)",
                         i, q4[i].w, q4[i].r, q4[i].c, exp4[i], er4[i], ec4[i]);
            end
        end
        n_cmp++;
        if (gap_viol != 0) begin
            n_bad++;
            $display("FAIL gap_valid_after_idle: got %0d want 0", gap_viol);
        end
    endtask

    task automatic test_back_to_back;
        int acc;
        int nfd;
        q4.delete();
        drive4(1'b0, 2, acc);
        n_cmp++;
        if (q4.size() != 8) begin
            n_bad++;
            $display("FAIL b2b_count: got %0d want 8", q4.size());
        end
        nfd = 0;
        foreach (q4[i]) if (q4[i].fd) nfd++;
        n_cmp++;
        if (nfd != 2) begin
            n_bad++;
            $display("FAIL b2b_frame_done: got %0d want 2", nfd);
        end
        if (q4.size() == 8) begin
            n_cmp++;
            if (q4[4].w !== 72'h4A4948464544424140) begin
                n_bad++;
                $display("FAIL b2b_win4: got %h want 4a4948464544424140", q4[4].w);
            end
            n_cmp++;
            if (q4[7].w !== 72'h4F4E4D4B4A49474645 || !q4[3].fd || !q4[7].fd) begin
                n_bad++;
                $display("FAIL b2b_win7: got %h fd3=%b fd7=%b want 4f4e4d4b4a49474645 1 1",
                         q4[7].w, q4[3].fd, q4[7].fd);
            end
        end
    endtask

    task automatic test_reset_mid;
        int acc;
        q4.delete();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            iv4 = 1'b1;
            px4 = 8'(i);
        end
        @(negedge clk);
        rst4 = 1'b0;
        px4  = 8'hEE;
        @(negedge clk);
        rst4 = 1'b1;
        iv4  = 1'b0;
        n_cmp++;
        if (q4.size() != 0) begin
            n_bad++;
            $display("FAIL rstmid_early: got %0d windows want 0", q4.size());
        end
        drive4(1'b0, 1, acc);
        n_cmp++;
        if (q4.size() != 4) begin
            n_bad++;
            $display("FAIL rstmid_count: got %0d want 4", q4.size());
        end
        if (q4.size() > 0) begin
            n_cmp++;
            if (q4[0].cyc != acc || q4[0].w !== 72'h0A0908060504020100
                || q4[0].r != 2 || q4[0].c != 2) begin
                n_bad++;
                $display("FAIL rstmid_first: got %h (%0d,%0d) cyc %0d want 0a0908060504020100 (2,2) cyc %0d",
                         q4[0].w, q4[0].r, q4[0].c, q4[0].cyc, acc);
            end
        end
    endtask

    task automatic test_8x8;
        logic [7:0]  img [64];
        logic [71:0] ew;
        int          idx;
        foreach (img[i]) img[i] = 8'($urandom);
        q8.delete();
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            iv8 = 1'b1;
            px8 = img[i];
        end
        @(negedge clk);
        iv8 = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (q8.size() != 36) begin
            n_bad++;
            $display("FAIL img8_count: got %0d want 36", q8.size());
        end
        idx = 0;
        for (int r = 2; r < 8; r++) begin
            for (int c = 2; c < 8; c++) begin
                for (int k = 0; k < 9; k++)
                    ew[k*8 +: 8] = img[(r - 2 + k / 3) * 8 + (c - 2 + k % 3)];
                if (idx < q8.size()) begin
                    n_cmp++;
                    if (q8[idx].w !== ew || q8[idx].r != r || q8[idx].c != c
                        || q8[idx].fd !== (idx == 35)) begin
                        n_bad++;
                        $display("FAIL img8_win%0d: got %h (%0d,%0d) fd=%b want %h (%0d,%0d) fd=%b",
                                 idx, q8[idx].w, q8[idx].r, q8[idx].c, q8[idx].fd,
                                 ew, r, c, idx == 35);
                    end
                end
                idx++;
            end
        end
    endtask

    initial begin
        exp4[0] = 72'h0A0908060504020100; er4[0] = 2; ec4[0] = 2;
        exp4[1] = 72'h0B0A09070605030201; er4[1] = 2; ec4[1] = 3;
        exp4[2] = 72'h0E0D0C0A0908060504; er4[2] = 3; ec4[2] = 2;
        exp4[3] = 72'h0F0E0D0B0A09070605; er4[3] = 3; ec4[3] = 3;
        test_reset();
        test_basic();
        test_gapped();
        test_back_to_back();
        test_reset_mid();
        test_8x8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
